// File: rtl/cpu_0_oci_dct_unpacker_if.sv
// Trace word in / code stream out bundle for the OCI DCT unpacker.
// The producer/consumer side uses master; the unpacker uses slave.
interface cpu_0_oci_dct_unpacker_if #(
    parameter int BUF_W = 30
);
    logic [BUF_W-1:0] dct_buffer;
    logic [3:0]       dct_count;
    logic             dct_load;
    logic [1:0]       frame_data;
    logic             frame_valid;
    logic             frame_ready;
    logic             frame_last;
    logic             busy;
    logic             overrun;
    logic             overrun_clr;

    modport master (
        output dct_buffer, dct_count, dct_load, frame_ready, overrun_clr,
        input  frame_data, frame_valid, frame_last, busy, overrun
    );

    modport slave (
        input  dct_buffer, dct_count, dct_load, frame_ready, overrun_clr,
        output frame_data, frame_valid, frame_last, busy, overrun
    );
endinterface

// File: rtl/cpu_0_oci_dct_unpacker.sv
// Replays packed 2-bit DCT codes one per handshake, oldest first.
// Holds one active word being shifted out and one pending word behind it.
//
// state | meaning
// IDLE  | no active word, nothing presented downstream
// SHIFT | active word presenting shreg[1:0], pending slot may be occupied
module cpu_0_oci_dct_unpacker #(
    parameter int BUF_W   = 30,
    parameter int MAX_CNT = 15
) (
    input  logic                     clk,
    input  logic                     reset,
    cpu_0_oci_dct_unpacker_if.slave  bus
);
    localparam int CNT_W = $clog2(MAX_CNT + 1);
    localparam int SH_W  = $clog2(BUF_W + 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state;
    logic [BUF_W-1:0] shreg;
    logic [BUF_W-1:0] pend_buf;
    logic [CNT_W-1:0] remain;
    logic [CNT_W-1:0] pend_cnt;
    logic             pend_full;
    logic             overrun_r;
    logic             busy_r;

    logic [SH_W-1:0]  shamt;
    logic [BUF_W-1:0] aligned;
    logic             load_ok;
    logic             hs;
    logic             end_word;

    // Newest code sits at the top, so right-aligning puts the oldest at [1:0].
    assign shamt    = SH_W'(BUF_W - 2 * int'(bus.dct_count));
    assign aligned  = bus.dct_buffer >> shamt;
    assign load_ok  = bus.dct_load && (bus.dct_count != '0);
    assign hs       = (state == SHIFT) && bus.frame_ready;
    assign end_word = hs && (remain == CNT_W'(1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            shreg     <= '0;
            pend_buf  <= '0;
            remain    <= '0;
            pend_cnt  <= '0;
            pend_full <= 1'b0;
            overrun_r <= 1'b0;
            busy_r    <= 1'b0;
        end else begin
            if (bus.overrun_clr) begin
                overrun_r <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (load_ok) begin
                        shreg  <= aligned;
                        remain <= bus.dct_count;
                        state  <= SHIFT;
                        busy_r <= 1'b1;
                    end else begin
                        busy_r <= 1'b0;
                    end
                end
                SHIFT: begin
                    if (end_word) begin
                        if (pend_full) begin
                            shreg     <= pend_buf;
                            remain    <= pend_cnt;
                            pend_full <= load_ok;
                            busy_r    <= 1'b1;
                            if (load_ok) begin
                                pend_buf <= aligned;
                                pend_cnt <= bus.dct_count;
                            end
                        end else if (load_ok) begin
                            // Word arriving on the final handshake goes straight to active: no bubble.
                            shreg  <= aligned;
                            remain <= bus.dct_count;
                            busy_r <= 1'b1;
                        end else begin
                            shreg  <= '0;
                            remain <= '0;
                            state  <= IDLE;
                            busy_r <= 1'b0;
                        end
                    end else begin
                        busy_r <= 1'b1;
                        if (hs) begin
                            shreg  <= shreg >> 2;
                            remain <= remain - CNT_W'(1);
                        end
                        if (load_ok) begin
                            if (!pend_full) begin
                                pend_buf  <= aligned;
                                pend_cnt  <= bus.dct_count;
                                pend_full <= 1'b1;
                            end else begin
                                overrun_r <= 1'b1;
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.frame_valid = (state == SHIFT);
    assign bus.frame_data  = shreg[1:0];
    assign bus.frame_last  = (state == SHIFT) && (remain == CNT_W'(1));
    assign bus.busy        = busy_r;
    assign bus.overrun     = overrun_r;
endmodule

// File: tb/tb_cpu_0_oci_dct_unpacker.sv
// Bench for the DCT unpacker: directed scenarios plus random traffic against a word/code queue model.
module tb_cpu_0_oci_dct_unpacker;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    cpu_0_oci_dct_unpacker_if bus();

    cpu_0_oci_dct_unpacker dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int total = 0;
    int bad   = 0;

    // Model: codes remaining per held word (front = active) and the flat code stream.
    int         words[$];
    logic [1:0] codes[$];
    logic       ovr_m;

    int dut_frames;
    int dut_lasts;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        words.delete();
        codes.delete();
        ovr_m = 1'b0;
    endtask

    task automatic model_edge(input logic ld, input logic [3:0] cnt, input logic [29:0] bv,
                              input logic rdy, input logic clr);
        bit hs;
        bit lastc;
        bit acc;
        int n;
        hs    = (words.size() > 0) && rdy;
        lastc = hs && (words[0] == 1);
        acc   = ld && (cnt != 0) && ((words.size() < 2) || lastc);
        if (hs) begin
            void'(codes.pop_front());
            words[0] = words[0] - 1;
            if (words[0] == 0) void'(words.pop_front());
        end
        if (clr) ovr_m = 1'b0;
        if (ld && (cnt != 0) && !acc) ovr_m = 1'b1;
        if (acc) begin
            n = int'(cnt);
            words.push_back(n);
            for (int k = 0; k < n; k++) codes.push_back(bv[30 - 2*n + 2*k +: 2]);
        end
    endtask

    task automatic check_outputs();
        chk("valid", bus.frame_valid, 32'(words.size() > 0));
        chk("busy", bus.busy, 32'(words.size() > 0));
        chk("overrun", bus.overrun, 32'(ovr_m));
        if (words.size() > 0) begin
            chk("data", bus.frame_data, 32'(codes[0]));
            chk("last", bus.frame_last, 32'(words[0] == 1));
        end else begin
            chk("last_idle", bus.frame_last, 0);
        end
    endtask

    task automatic step(input logic ld, input logic [3:0] cnt, input logic [29:0] bv,
                        input logic rdy, input logic clr);
        bus.dct_load    = ld;
        bus.dct_count   = cnt;
        bus.dct_buffer  = bv;
        bus.frame_ready = rdy;
        bus.overrun_clr = clr;
        if (bus.frame_valid && rdy) begin
            dut_frames++;
            if (bus.frame_last) dut_lasts++;
        end
        @(posedge clk);
        model_edge(ld, cnt, bv, rdy, clr);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic drain(input int max_cycles);
        for (int i = 0; i < max_cycles && words.size() > 0; i++) step(1'b0, 4'd0, '0, 1'b1, 1'b0);
        chk("drain_busy", bus.busy, 0);
    endtask

    int gap;
    logic [29:0] rbuf;

    initial begin
        reset = 1'b1;
        bus.dct_load = 1'b0; bus.dct_count = '0; bus.dct_buffer = '0;
        bus.frame_ready = 1'b0; bus.overrun_clr = 1'b0;
        model_clear();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", bus.frame_valid, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_overrun", bus.overrun, 0);
        chk("rst_last", bus.frame_last, 0);
        reset = 1'b0;

        // Two codes: oldest 00 at [27:26], newest 11 at [29:28].
        step(1'b1, 4'd2, 30'h3000_0000, 1'b1, 1'b0);
        chk("t2_valid_lat", bus.frame_valid, 1);
        chk("t2_code0", bus.frame_data, 0);
        step(1'b0, 4'd0, '0, 1'b1, 1'b0);
        chk("t2_code1", bus.frame_data, 3);
        chk("t2_last", bus.frame_last, 1);
        step(1'b0, 4'd0, '0, 1'b1, 1'b0);
        chk("t2_idle", bus.frame_valid, 0);
        step(1'b1, 4'd2, 30'h3C00_0000, 1'b1, 1'b0);
        drain(10);

        // Full word, no alignment shift.
        dut_frames = 0; dut_lasts = 0;
        step(1'b1, 4'd15, 30'h1B1B_1B1B, 1'b1, 1'b0);
        chk("t3_code0", bus.frame_data, 3);
        for (int i = 0; i < 20; i++) step(1'b0, 4'd0, '0, 1'b1, 1'b0);
        chk("t3_frames", dut_frames, 15);
        chk("t3_lasts", dut_lasts, 1);

        // Backpressure on 3-code words.
        for (int w = 0; w < 6; w++) begin
            step(1'b1, 4'd3, 30'($urandom), 1'($urandom), 1'b0);
            for (int i = 0; i < 12; i++) step(1'b0, 4'd0, '0, 1'($urandom), 1'b0);
        end
        drain(40);

        // Pending fill, drop, then back-to-back streaming.
        step(1'b1, 4'd4, 30'($urandom), 1'b0, 1'b0);
        step(1'b1, 4'd5, 30'($urandom), 1'b0, 1'b0);
        step(1'b1, 4'd6, 30'($urandom), 1'b0, 1'b0);
        chk("t5_overrun", bus.overrun, 1);
        gap = 0;
        for (int i = 0; i < 12 && bus.busy; i++) begin
            step(1'b0, 4'd0, '0, 1'b1, 1'b0);
            if (bus.busy && !bus.frame_valid) gap++;
        end
        chk("t5_no_bubble", gap, 0);
        chk("t5_done", bus.busy, 0);
        step(1'b0, 4'd0, '0, 1'b0, 1'b1);
        chk("t5_clr", bus.overrun, 0);

        // Zero-count load is ignored.
        step(1'b1, 4'd0, 30'h3FFF_FFFF, 1'b1, 1'b0);
        chk("t6_zero_valid", bus.frame_valid, 0);
        chk("t6_zero_busy", bus.busy, 0);

        // Load on the final handshake of the active word with pending full.
        step(1'b1, 4'd2, 30'($urandom), 1'b0, 1'b0);
        step(1'b1, 4'd3, 30'($urandom), 1'b0, 1'b0);
        step(1'b0, 4'd0, '0, 1'b1, 1'b0);
        chk("t6_last_pre", bus.frame_last, 1);
        step(1'b1, 4'd4, 30'($urandom), 1'b1, 1'b0);
        chk("t6_no_overrun", bus.overrun, 0);
        drain(20);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            rbuf = 30'($urandom);
            step(1'($urandom_range(0, 3) == 0), 4'($urandom_range(0, 15)), rbuf,
                 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 7) == 0));
        end
        drain(60);

        // Asynchronous reset mid-word with overrun set.
        step(1'b1, 4'd10, 30'($urandom), 1'b0, 1'b0);
        step(1'b1, 4'd7, 30'($urandom), 1'b0, 1'b0);
        step(1'b1, 4'd7, 30'($urandom), 1'b0, 1'b0);
        chk("t1_pre_overrun", bus.overrun, 1);
        #2 reset = 1'b1;
        #1;
        chk("t1_valid", bus.frame_valid, 0);
        chk("t1_busy", bus.busy, 0);
        chk("t1_overrun", bus.overrun, 0);
        model_clear();
        bus.dct_load = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        step(1'b0, 4'd0, '0, 1'b1, 1'b0);
        chk("t1_idle", bus.frame_valid, 0);
        step(1'b1, 4'd1, 30'h3000_0000, 1'b1, 1'b0);
        chk("t1_after_code", bus.frame_data, 3);
        drain(5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
